// File: rtl/frame_loader.sv
// frame_loader: packs a serial 1-bit pixel stream into WIDTH-bit frames (ping-pong pair) and feeds the classifier.
// Latency: cls_en rises on the 2nd clock edge after a frame's last pixel; result published 1 cycle after accepted cls_ready.
// Backpressure: pix_ready drops while both buffers hold frames; HOLD waits on cls_ready with no timeout.
// Optional: define FRAME_LOADER_SOF_EN to add pix_sof realignment and the sticky sof_err flag.
module frame_loader #(
  parameter int WIDTH    = 25,
  parameter int MIN_HOLD = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_data,
`ifdef FRAME_LOADER_SOF_EN
  input  logic             pix_sof,
  output logic             sof_err,
`endif
  output logic             pix_ready,
  output logic [WIDTH-1:0] cls_in,
  output logic             cls_en,
  input  logic             cls_ready,
  input  logic [1:0]       cls_out,
  output logic [1:0]       res_class,
  output logic             res_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [CW-1:0] LAST_PIX  = CW'(WIDTH - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(MIN_HOLD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;

  logic [1:0][WIDTH-1:0] fbuf_q, fbuf_d;
  logic [1:0]            full_q, full_d, full_set, full_clr;
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_base;
  logic                  rdy_en_q, rdy_en_d;
  state_t                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [WIDTH-1:0]      cls_in_q, cls_in_d;
  logic                  cls_en_q, cls_en_d;
  logic [1:0]            res_class_q, res_class_d;
  logic                  res_valid_q, res_valid_d;
  logic                  xfer;
`ifdef FRAME_LOADER_SOF_EN
  logic                  sof_err_q, sof_err_d;
`endif

  // rdy_en_q keeps pix_ready low during reset and for the first cycle after it
  assign pix_ready = rdy_en_q & ~full_q[wsel_q];
  assign xfer      = pix_valid & pix_ready;
  assign cls_in    = cls_in_q;
  assign cls_en    = cls_en_q;
  assign res_class = res_class_q;
  assign res_valid = res_valid_q;
  assign busy      = (|full_q) | (state_q != IDLE);
`ifdef FRAME_LOADER_SOF_EN
  assign sof_err   = sof_err_q;
`endif

  // Fill side: shift accepted pixels into the write buffer, mark it full on the last pixel
  always_comb begin
    rdy_en_d = 1'b1;
    fbuf_d   = fbuf_q;
    wsel_d   = wsel_q;
    cnt_d    = cnt_q;
    cnt_base = cnt_q;
    full_set = 2'b00;
`ifdef FRAME_LOADER_SOF_EN
    sof_err_d = sof_err_q;
`endif
    if (xfer) begin
`ifdef FRAME_LOADER_SOF_EN
      // A start-of-frame pixel restarts the frame; any partial frame is dropped
      if (pix_sof) begin
        cnt_base = '0;
        if (cnt_q != '0) sof_err_d = 1'b1;
      end
`endif
      fbuf_d[wsel_q] = {fbuf_q[wsel_q][WIDTH-2:0], pix_data};
      if (cnt_base == LAST_PIX) begin
        full_set[wsel_q] = 1'b1;
        wsel_d           = ~wsel_q;
        cnt_d            = '0;
      end else begin
        cnt_d = cnt_base + CW'(1);
      end
    end
  end

  // Classify side: present a full buffer, hold for MIN_HOLD cycles, capture result, force one low cycle
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cls_in_d    = cls_in_q;
    cls_en_d    = cls_en_q;
    res_class_d = res_class_q;
    res_valid_d = 1'b0;
    rsel_d      = rsel_q;
    full_clr    = 2'b00;
    case (state_q)
      IDLE: begin
        if (full_q[rsel_q]) begin
          cls_in_d = fbuf_q[rsel_q];
          cls_en_d = 1'b1;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hold_q != LAST_HOLD) begin
          hold_d = hold_q + HW'(1);
        end else if (cls_ready) begin
          res_class_d      = cls_out;
          res_valid_d      = 1'b1;
          full_clr[rsel_q] = 1'b1;
          rsel_d           = ~rsel_q;
          cls_en_d         = 1'b0;
          state_d          = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Fill completion and release always target different buffers, so both apply
    full_d = (full_q | full_set) & ~full_clr;
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbuf_q      <= '0;
      full_q      <= '0;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= '0;
      cls_in_q    <= '0;
      cls_en_q    <= 1'b0;
      res_class_q <= 2'b00;
      res_valid_q <= 1'b0;
`ifdef FRAME_LOADER_SOF_EN
      sof_err_q   <= 1'b0;
`endif
    end else begin
      fbuf_q      <= fbuf_d;
      full_q      <= full_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= rdy_en_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      cls_in_q    <= cls_in_d;
      cls_en_q    <= cls_en_d;
      res_class_q <= res_class_d;
      res_valid_q <= res_valid_d;
`ifdef FRAME_LOADER_SOF_EN
      sof_err_q   <= sof_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed frames against a queue-based frame/result model, compared every falling edge.
// The classifier is emulated by a responder that recognises the circle and cross patterns.
module tb_frame_loader;

  localparam int          WIDTH    = 25;
  localparam int          MIN_HOLD = 6;
  localparam logic [24:0] CROSS    = 25'h1151151;
  localparam logic [24:0] CIRCLE   = 25'h0454544;
  localparam logic [24:0] OTHER    = 25'h1555555;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_data  = 1'b0;
  logic        pix_ready;
  logic [24:0] cls_in;
  logic        cls_en;
  logic        cls_ready = 1'b0;
  logic [1:0]  cls_out   = 2'b00;
  logic [1:0]  res_class;
  logic        res_valid;
  logic        busy;
`ifdef FRAME_LOADER_SOF_EN
  logic        pix_sof   = 1'b0;
  logic        sof_err;
`endif

  int checks = 0;
  int errors = 0;

  frame_loader #(.WIDTH(WIDTH), .MIN_HOLD(MIN_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
`ifdef FRAME_LOADER_SOF_EN
    .pix_sof   (pix_sof),
    .sof_err   (sof_err),
`endif
    .pix_ready (pix_ready),
    .cls_in    (cls_in),
    .cls_en    (cls_en),
    .cls_ready (cls_ready),
    .cls_out   (cls_out),
    .res_class (res_class),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [24:0] m_q[$];          // completed frames held in buffers, oldest first
  logic [24:0] m_part   = '0;
  int          m_pcnt   = 0;
  bit          m_rdy_en = 0;
  bit          m_en     = 0;
  int          m_en_edges   = 0;
  int          m_idle_edges = 1;  // edges seen with cls_en low since the last release
  logic [24:0] m_cls_in  = '0;
  logic [1:0]  m_res     = '0;
  bit          m_res_vld = 0;
  bit          m_sof_err = 0;
  int          m_acc     = 0;
  bit          m_rdy, m_got, m_rel;
  logic [24:0] m_done;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_part = '0; m_pcnt = 0; m_rdy_en = 0; m_en = 0; m_en_edges = 0; m_idle_edges = 1;
      m_cls_in = '0; m_res = '0; m_res_vld = 0; m_sof_err = 0;
    end else begin
      m_rdy = m_rdy_en && (m_q.size() < 2);
      m_rdy_en = 1;
      m_got = 0; m_rel = 0; m_res_vld = 0;
      if (m_en) begin
        m_en_edges++;
        if (m_en_edges >= MIN_HOLD && cls_ready === 1'b1) begin
          m_res = cls_out; m_res_vld = 1; m_en = 0; m_idle_edges = 0; m_rel = 1;
        end
      end else begin
        if (m_idle_edges >= 1 && m_q.size() > 0) begin
          m_en = 1; m_en_edges = 0; m_cls_in = m_q[0];
        end
        m_idle_edges++;
      end
      if (pix_valid && m_rdy) begin
        m_acc++;
`ifdef FRAME_LOADER_SOF_EN
        if (pix_sof) begin
          if (m_pcnt != 0) m_sof_err = 1;
          m_pcnt = 0;
        end
`endif
        m_part = {m_part[23:0], pix_data};
        m_pcnt++;
        if (m_pcnt == WIDTH) begin m_got = 1; m_done = m_part; m_pcnt = 0; end
      end
      if (m_rel) void'(m_q.pop_front());
      if (m_got) m_q.push_back(m_done);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("pix_ready", 32'(pix_ready), 32'(m_rdy_en && (m_q.size() < 2)));
    chk("cls_en",    32'(cls_en),    32'(m_en));
    chk("cls_in",    32'(cls_in),    32'(m_cls_in));
    chk("res_class", 32'(res_class), 32'(m_res));
    chk("res_valid", 32'(res_valid), 32'(m_res_vld));
    chk("busy",      32'(busy),      32'(m_q.size() > 0 || m_en || m_idle_edges == 0));
`ifdef FRAME_LOADER_SOF_EN
    chk("sof_err",   32'(sof_err),   32'(m_sof_err));
`endif
  end

  // ---------------- classifier responder ----------------
  bit         hold_off  = 0;
  int         rdy_after = 2;
  logic [1:0] other_out = 2'd0;
  int         rsp_cnt   = 0;

  initial forever begin
    @(negedge clk);
    if (cls_en !== 1'b1) begin
      rsp_cnt = 0; cls_ready = 1'b0; cls_out = 2'd0;
    end else begin
      rsp_cnt++;
      if (cls_in == CIRCLE)     cls_out = 2'd1;
      else if (cls_in == CROSS) cls_out = 2'd2;
      else                      cls_out = other_out;
      cls_ready = !hold_off && (rsp_cnt >= rdy_after);
    end
  end

  // ---------------- event logs ----------------
  logic [1:0]  res_log[$];
  logic [24:0] en_log[$];
  int          run_log[$];
  int          en_run = 0;
  bit          en_prev = 0;
  int          rdy_low_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (res_valid === 1'b1) res_log.push_back(res_class);
    if (pix_ready === 1'b0) rdy_low_cnt++;
    if (cls_en === 1'b1) begin
      if (!en_prev) en_log.push_back(cls_in);
      en_run++;
    end else if (en_prev) begin
      run_log.push_back(en_run);
      en_run = 0;
    end
    en_prev = (cls_en === 1'b1);
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic send_pix(input logic d);
    int guard;
    guard = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    while (pix_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL send_timeout: pix_ready stuck at %b, required 1", pix_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [24:0] f, input int n);
    for (int i = 0; i < n; i++) send_pix(f[24-i]);
    pix_valid = 1'b0;
  endtask

  task automatic wait_en(input logic lvl, input string nm);
    int guard;
    guard = 0;
    while (cls_en !== lvl && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL %s: cls_en stuck at %b, required %b", nm, cls_en, lvl);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy !== 1'b0 || cls_en !== 1'b0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b cls_en=%b, required 0 0", busy, cls_en);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, simulation incomplete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r0, e0, n0, acc0, rl0;
    logic [24:0] f;

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_cls_en",    32'(cls_en),    0);
    chk("rst_cls_in",    32'(cls_in),    0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy",      32'(busy),      0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pix_ready_after_1", 32'(pix_ready), 1);

    // Test 1: single cross frame, ready from the 2nd en cycle
    rdy_after = 2; hold_off = 0; other_out = 2'd0;
    r0 = res_log.size(); e0 = en_log.size(); n0 = run_log.size();
    send_frame(CROSS, 25);
    wait_en(1'b1, "t1_en_rise");
    wait_en(1'b0, "t1_en_fall");
    chk("t1_gap_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 0);
    wait_idle();
    chk("t1_en_count", 32'(en_log.size() - e0), 1);
    chk("t1_cls_in",   32'(en_log[e0]), 32'(25'h1151151));
    chk("t1_en_len",   32'(run_log[n0]), 6);
    chk("t1_res_cnt",  32'(res_log.size() - r0), 1);
    chk("t1_res",      32'(res_log[r0]), 2);

    // Test 2: circle then cross back-to-back, ready after 10 en cycles
    rdy_after = 10;
    r0 = res_log.size(); e0 = en_log.size(); n0 = run_log.size(); rl0 = rdy_low_cnt;
    send_frame(CIRCLE, 25);
    send_frame(CROSS, 25);
    chk("t2_pix_ready_low_cycles", 32'(rdy_low_cnt - rl0), 0);
    wait_idle();
    chk("t2_res_cnt", 32'(res_log.size() - r0), 2);
    chk("t2_res0",    32'(res_log[r0]), 1);
    chk("t2_res1",    32'(res_log[r0+1]), 2);
    chk("t2_cls_in0", 32'(en_log[e0]), 32'(CIRCLE));
    chk("t2_cls_in1", 32'(en_log[e0+1]), 32'(CROSS));
    chk("t2_en_len0", 32'(run_log[n0]), 10);

    // Test 3: classifier stalled, three frames offered, backpressure after 50 pixels
    rdy_after = 3; hold_off = 1;
    r0 = res_log.size(); acc0 = m_acc;
    fork
      begin
        send_frame(CIRCLE, 25);
        send_frame(CROSS, 25);
        send_frame(CIRCLE, 25);
      end
      begin
        repeat (75) @(negedge clk);
        chk("t3_accepted", 32'(m_acc - acc0), 50);
        chk("t3_pix_ready", 32'(pix_ready), 0);
        chk("t3_busy", 32'(busy), 1);
        hold_off = 0;
      end
    join
    wait_idle();
    chk("t3_res_cnt", 32'(res_log.size() - r0), 3);
    chk("t3_res0",    32'(res_log[r0]), 1);
    chk("t3_res1",    32'(res_log[r0+1]), 2);
    chk("t3_res2",    32'(res_log[r0+2]), 1);

    // Test 4: reset during classification with a 12-pixel partial frame
    hold_off = 1; rdy_after = 2;
    send_frame(CROSS, 25);
    send_frame(CIRCLE, 12);
    chk("t4_en_before_rst", 32'(cls_en), 1);
    r0 = res_log.size();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_cls_en",    32'(cls_en), 0);
    chk("t4_rst_pix_ready", 32'(pix_ready), 0);
    chk("t4_rst_busy",      32'(busy), 0);
    chk("t4_rst_cls_in",    32'(cls_in), 0);
    hold_off = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_no_res_on_rst", 32'(res_log.size() - r0), 0);
    e0 = en_log.size();
    send_frame(CIRCLE, 25);
    wait_idle();
    chk("t4_cls_in",   32'(en_log[e0]), 32'(CIRCLE));
    chk("t4_res_cnt",  32'(res_log.size() - r0), 1);
    chk("t4_res",      32'(res_log[r0]), 1);

    // Test 5: invalid class passes through
    other_out = 2'd3;
    r0 = res_log.size();
    send_frame(OTHER, 25);
    wait_idle();
    chk("t5_res_cnt", 32'(res_log.size() - r0), 1);
    chk("t5_res",     32'(res_log[r0]), 3);
    chk("t5_idle",    32'(busy), 0);
    other_out = 2'd0;

`ifdef FRAME_LOADER_SOF_EN
    // Test 6: start-of-frame realignment
    r0 = res_log.size(); e0 = en_log.size();
    chk("t6_sof_err_init", 32'(sof_err), 0);
    f = CROSS;
    for (int i = 0; i < 7; i++) send_pix(f[24-i]);
    pix_sof = 1'b1; send_pix(f[17]); pix_sof = 1'b0;
    pix_sof = 1'b1; send_pix(f[24]); pix_sof = 1'b0;
    for (int i = 1; i < 25; i++) send_pix(f[24-i]);
    pix_valid = 1'b0;
    wait_idle();
    chk("t6_sof_err",  32'(sof_err), 1);
    chk("t6_en_count", 32'(en_log.size() - e0), 1);
    chk("t6_cls_in",   32'(en_log[e0]), 32'(25'h1151151));
    chk("t6_res_cnt",  32'(res_log.size() - r0), 1);
`else
    f = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
